// File: rtl/int_vp_pkg.sv
// int_vp_pkg -- shared constants and types for the internal VP generator.
//   Rate codes, default clocks-per-frame at 25 MHz, and the lock-state enum.
package int_vp_pkg;

  // Frame-rate codes carried on rate_sel
  localparam logic [1:0] RATE_50   = 2'd0;
  localparam logic [1:0] RATE_5994 = 2'd1;
  localparam logic [1:0] RATE_60   = 2'd2;
  localparam logic [1:0] RATE_48   = 2'd3;

  // Default clocks per frame for a 25 MHz clock
  localparam int unsigned P_50_DEF   = 500000;
  localparam int unsigned P_5994_DEF = 417084;
  localparam int unsigned P_60_DEF   = 416667;
  localparam int unsigned P_48_DEF   = 520833;

  // External-lock state machine states
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage : int_vp_pkg

// File: rtl/int_vp_ext_sync.sv
// int_vp_ext_sync -- brings the asynchronous ext_vp into the clk domain and
// produces a one-clock rising-edge pulse.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   ext_vp   : external VP, asynchronous, active-high
//   ext_edge : registered 1-clk pulse, 3 clocks after the ext_vp rise
module int_vp_ext_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_vp,
  output logic ext_edge
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  // Two-flop synchroniser, one history flop, registered edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_3   <= 1'b0;
      ext_edge <= 1'b0;
    end else begin
      sync_1   <= ext_vp;
      sync_2   <= sync_1;
      sync_3   <= sync_2;
      ext_edge <= sync_2 & ~sync_3;
    end
  end

endmodule : int_vp_ext_sync

// File: rtl/int_vp_gen_mr.sv
// int_vp_gen_mr -- internal vertical-pulse generator with selectable frame
// rate and optional lock to an external VP.
//   clk      : 25 MHz clock
//   rst_n    : asynchronous active-low reset
//   rate_sel : frame rate code (0=50, 1=59.94, 2=60, 3=48 Hz), taken at frame end
//   ext_vp   : external VP, asynchronous, active-high
//   vp       : internal VP pulse, PW clocks wide
//   locked   : high while locked to ext_vp
//   phase    : current frame counter value
// Build option: define INT_VP_EXTLOCK_EN to include the external-lock logic;
// without it ext_vp is ignored, locked is 0 and the block free-runs.
module int_vp_gen_mr
  import int_vp_pkg::*;
#(
  parameter int unsigned CNT_W  = 20,
  parameter int unsigned P_50   = P_50_DEF,
  parameter int unsigned P_5994 = P_5994_DEF,
  parameter int unsigned P_60   = P_60_DEF,
  parameter int unsigned P_48   = P_48_DEF,
  parameter int unsigned PW     = 1,
  parameter int unsigned TOL    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       rate_sel,
  input  logic             ext_vp,
  output logic             vp,
  output logic             locked,
  output logic [CNT_W-1:0] phase
);

  // Terminal counts (period - 1) per rate
  localparam logic [CNT_W-1:0] LAST_50   = CNT_W'(P_50 - 1);
  localparam logic [CNT_W-1:0] LAST_5994 = CNT_W'(P_5994 - 1);
  localparam logic [CNT_W-1:0] LAST_60   = CNT_W'(P_60 - 1);
  localparam logic [CNT_W-1:0] LAST_48   = CNT_W'(P_48 - 1);
  localparam logic [7:0]       PW_M1     = 8'(PW - 1);

  logic [CNT_W-1:0] qa;
  logic [1:0]       rate_q;
  logic [7:0]       width_cnt;
  logic [CNT_W-1:0] last_c;
  logic             tc_c;
  logic             resync_c;
  logic             trig_c;

  // Terminal count for the rate latched at the start of this frame
  always_comb begin
    last_c = LAST_50;
    case (rate_q)
      RATE_50:   last_c = LAST_50;
      RATE_5994: last_c = LAST_5994;
      RATE_60:   last_c = LAST_60;
      RATE_48:   last_c = LAST_48;
      default:   last_c = LAST_50;
    endcase
  end

  assign tc_c  = (qa == last_c);
  assign phase = qa;

`ifdef INT_VP_EXTLOCK_EN

  localparam logic [CNT_W-1:0] TOL_Q     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] WLO_50    = CNT_W'(P_50 - 1 - TOL);
  localparam logic [CNT_W-1:0] WLO_5994  = CNT_W'(P_5994 - 1 - TOL);
  localparam logic [CNT_W-1:0] WLO_60    = CNT_W'(P_60 - 1 - TOL);
  localparam logic [CNT_W-1:0] WLO_48    = CNT_W'(P_48 - 1 - TOL);

  logic             ext_edge;
  logic [CNT_W-1:0] win_lo_c;
  logic             in_win_c;
  lock_state_t      state;
  logic [1:0]       miss;
  logic             edge_seen;

  int_vp_ext_sync u_ext_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ext_vp   (ext_vp),
    .ext_edge (ext_edge)
  );

  // Lower edge of the capture window for the current frame length
  always_comb begin
    win_lo_c = WLO_50;
    case (rate_q)
      RATE_50:   win_lo_c = WLO_50;
      RATE_5994: win_lo_c = WLO_5994;
      RATE_60:   win_lo_c = WLO_60;
      RATE_48:   win_lo_c = WLO_48;
      default:   win_lo_c = WLO_50;
    endcase
  end

  // Window wraps across the frame boundary: late tail or early head
  assign in_win_c = (qa >= win_lo_c) || (qa <= TOL_Q);
  assign resync_c = ext_edge;
  // An early resync (just after tc) would double-pulse, so it stays silent
  assign trig_c   = tc_c || (resync_c && (qa > TOL_Q));

  // Lock FSM with miss counter; an edge coincident with tc counts for that tc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FREE;
      miss      <= 2'd0;
      edge_seen <= 1'b0;
      locked    <= 1'b0;
    end else begin
      if (tc_c) begin
        edge_seen <= 1'b0;
      end else if (ext_edge) begin
        edge_seen <= 1'b1;
      end

      if (ext_edge) begin
        miss <= 2'd0;
        case (state)
          FREE: begin
            state  <= ACQ;
            locked <= 1'b0;
          end
          ACQ: begin
            if (in_win_c) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (!in_win_c) begin
              state  <= ACQ;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= FREE;
            locked <= 1'b0;
          end
        endcase
      end else if (tc_c && !edge_seen) begin
        if (miss != 2'd3) begin
          miss <= miss + 2'd1;
        end
        // Second consecutive missed frame drops the lock
        if ((miss >= 2'd1) && (state != FREE)) begin
          state  <= FREE;
          locked <= 1'b0;
        end
      end
    end
  end

`else

  logic             unused_ext_vp;
  // TOL only shapes the capture window, which is not built here
  localparam int unsigned tol_unused = TOL;

  assign unused_ext_vp = ext_vp;
  assign resync_c      = 1'b0;
  assign trig_c        = tc_c;
  assign locked        = 1'b0;

`endif

  // Frame counter and rate latch; rate only changes at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa     <= '0;
      rate_q <= RATE_50;
    end else begin
      if (tc_c || resync_c) begin
        qa <= '0;
      end else begin
        qa <= qa + CNT_W'(1);
      end
      if (tc_c) begin
        rate_q <= rate_sel;
      end
    end
  end

  // Pulse stretcher; a retrigger reloads the width so pulses merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp        <= 1'b0;
      width_cnt <= 8'd0;
    end else begin
      if (trig_c) begin
        vp        <= 1'b1;
        width_cnt <= PW_M1;
      end else if (vp) begin
        if (width_cnt == 8'd0) begin
          vp <= 1'b0;
        end else begin
          width_cnt <= width_cnt - 8'd1;
        end
      end
    end
  end

endmodule : int_vp_gen_mr

// File: tb/tb_int_vp_gen_mr.sv
// tb_int_vp_gen_mr -- self-checking bench for int_vp_gen_mr.
// A frame-level reference model runs alongside the DUT and is compared every
// cycle; directed scenarios add literal timing expectations.
module tb_int_vp_gen_mr;

  localparam int CNT_W = 20;
  localparam int PW    = 3;
  localparam int TOL   = 4;
`ifdef INT_VP_EXTLOCK_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       rate_sel = 2'd0;
  logic             ext_vp = 1'b0;
  logic             vp;
  logic             locked;
  logic [CNT_W-1:0] phase;

  always #5 clk = ~clk;

  int_vp_gen_mr #(
    .CNT_W (CNT_W),
    .P_50  (100),
    .P_5994(84),
    .P_60  (83),
    .P_48  (104),
    .PW    (PW),
    .TOL   (TOL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rate_sel(rate_sel),
    .ext_vp  (ext_vp),
    .vp      (vp),
    .locked  (locked),
    .phase   (phase)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int per_tab [4] = '{100, 84, 83, 104};
  int m_qa    = 0;
  int m_rate  = 0;
  int m_state = 0;   // 0 free, 1 acquiring, 2 locked
  int m_miss  = 0;
  bit m_seen  = 1'b0;
  bit xs [4]  = '{1'b0, 1'b0, 1'b0, 1'b0};  // ext_vp seen at the last 4 edges
  int m_cyc   = 0;   // clock edges since reset release
  int m_trig  = -1000;

  always @(posedge clk or negedge rst_n) begin : model_p
    int per;
    bit tc, edg, win, trig;
    if (!rst_n) begin
      m_qa = 0; m_rate = 0; m_state = 0; m_miss = 0; m_seen = 1'b0;
      xs = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_cyc = 0; m_trig = -1000;
    end else begin
      m_cyc++;
      per  = per_tab[m_rate];
      tc   = (m_qa == per - 1);
      edg  = EXT_EN && xs[2] && !xs[3];   // ext rise three edges ago
      win  = (m_qa >= per - 1 - TOL) || (m_qa <= TOL);
      trig = tc || (edg && (m_qa > TOL));
      if (trig) m_trig = m_cyc;
      if (edg) begin
        m_miss = 0;
        if (m_state == 0)      m_state = 1;
        else if (win)          m_state = 2;
        else                   m_state = 1;
      end else if (tc && !m_seen) begin
        m_miss = (m_miss < 3) ? m_miss + 1 : 3;
        if (m_miss >= 2 && m_state != 0) m_state = 0;
      end
      if (tc) m_seen = 1'b0;
      else if (edg) m_seen = 1'b1;
      if (tc) m_rate = int'(rate_sel);
      m_qa = (tc || edg) ? 0 : m_qa + 1;
      xs[3] = xs[2]; xs[2] = xs[1]; xs[1] = xs[0]; xs[0] = ext_vp;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en    = 1'b0;
  bit vp_prev   = 1'b0;
  int rise_cnt  = 0;
  int last_rise = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int d;
      d = m_cyc - m_trig;
      chk("vp", vp, (d >= 0 && d < PW) ? 1 : 0);
      chk("locked", locked, (m_state == 2) ? 1 : 0);
      chk("phase", phase, m_qa);
      if (vp && !vp_prev) begin
        rise_cnt++;
        last_rise = m_cyc;
      end
      vp_prev = vp;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rise(output int t);
    int start;
    int i;
    start = rise_cnt;
    i = 0;
    while (rise_cnt == start && i < 400) begin
      step(1);
      i++;
    end
    if (rise_cnt == start) chk("timeout_vp_rise", 0, 1);
    t = last_rise;
  endtask

  task automatic wait_phase(input int p);
    int i;
    i = 0;
    while (int'(phase) != p && i < 300) begin
      step(1);
      i++;
    end
    if (int'(phase) != p) chk("timeout_phase", phase, p);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int t0, t1, t2, t3;
    int gap, w;
    int i;

    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    step(3);
    chk("reset_vp", vp, 0);
    chk("reset_locked", locked, 0);
    chk("reset_phase", phase, 0);
    rst_n = 1'b1;

    // Free run at 50 Hz code: pulse every 100 clocks, first at 100
    wait_rise(t0);
    chk("first_vp_cycle", t0, 100);
    wait_rise(t1);
    chk("second_vp_cycle", t1, 200);

    // Rate change mid-frame: current frame keeps its length
    wait_phase(40);
    t0 = last_rise;
    rate_sel = 2'd1;
    wait_rise(t1);
    chk("rate_old_frame", t1 - t0, 100);
    wait_rise(t2);
    chk("rate_new_frame", t2 - t1, 84);
    rate_sel = 2'd0;
    wait_rise(t3);
    chk("rate_back_frame", t3 - t2, 84);

`ifdef INT_VP_EXTLOCK_EN
    // Lock: edges every 100 clocks, ACQ after first, LOCKED after second
    step(60);
    for (int k = 0; k < 3; k++) begin
      ext_vp = 1'b1;
      step(4);
      chk("lock_phase0", phase, 0);
      chk("lock_state", locked, (k > 0) ? 1 : 0);
      chk("lock_vp", vp, 1);
      step(1);
      ext_vp = 1'b0;
      step(95);
    end

    // Jump to qa=50 while locked: back to ACQ with a pulse
    wait_phase(47);
    ext_vp = 1'b1;
    step(4);
    chk("jump_phase0", phase, 0);
    chk("jump_unlocked", locked, 0);
    chk("jump_vp", vp, 1);
    step(1);
    ext_vp = 1'b0;
    step(95);
    ext_vp = 1'b1;
    step(4);
    chk("relock", locked, 1);
    chk("relock_phase0", phase, 0);
    step(1);
    ext_vp = 1'b0;

    // Loss: two missed frames drop to FREE, vp keeps its cadence
    t0 = last_rise;
    wait_rise(t1);
    chk("loss_interval1", t1 - t0, 100);
    step(1);
    chk("loss_still_locked", locked, 1);
    wait_rise(t2);
    chk("loss_interval2", t2 - t1, 100);
    chk("loss_free", locked, 0);
`endif

    // Randomised rates and external pulses, checked by the model
    for (i = 0; i < 40; i++) begin
      rate_sel = 2'($urandom_range(0, 3));
      gap = $urandom_range(10, 220);
      w   = $urandom_range(1, 6);
      if (($urandom % 4) != 0) begin
        ext_vp = 1'b1;
        step(w);
        ext_vp = 1'b0;
      end
      step(gap);
    end
    // Periodic edges at the current frame length to exercise lock/retain
    rate_sel = 2'd2;
    step(250);
    for (i = 0; i < 6; i++) begin
      ext_vp = 1'b1;
      step(3);
      ext_vp = 1'b0;
      step(80 + int'($urandom_range(0, 6)));
    end
    step(300);

    // Reset during a pulse
    rate_sel = 2'd0;
    i = 0;
    while (!vp && i < 300) begin
      step(1);
      i++;
    end
    chk("pre_reset_vp_seen", vp, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_pulse_vp", vp, 0);
    chk("reset_mid_pulse_phase", phase, 0);
    chk("reset_mid_pulse_locked", locked, 0);
    step(2);
    rst_n = 1'b1;
    wait_rise(t0);
    chk("post_reset_vp_cycle", t0, 100);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_int_vp_gen_mr
